pf_io_delay_ctrl: RTL

- Sequencer for the dynamic delay line of one PF_IO instance built with DYN_DELAY_LINE_EN=1.
- Accepts tap commands from fabric logic (training, calibration or register interface) over a valid/ready handshake.
- Drives the IOD DELAY_LINE_LOAD, DELAY_LINE_MOVE and DELAY_LINE_DIRECTION pins with correctly spaced single-cycle pulses.
- Keeps a shadow tap count and reports range errors using DELAY_LINE_OUT_OF_RANGE.

---
 rtl/pf_io_delay_pkg.sv | 29 ++
 rtl/pf_io_delay_settle_timer.sv | 32 +++
 rtl/pf_io_delay_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pf_io_delay_pkg.sv
// Shared definitions for the PF_IO dynamic delay-line sequencer.
// Holds command encodings, FSM state enum and default sizing constants so
// that other delay-line control blocks (e.g. a per-lane arbiter) reuse them.
package pf_io_delay_pkg;

    localparam int unsigned TAP_W_DEF         = 7;
    localparam int unsigned MAX_TAP_DEF       = 127;
    localparam int unsigned DEFAULT_TAP_DEF   = 1;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned SETTLE_CNT_W      = 4;
    localparam int unsigned CMD_OP_W          = 2;

    typedef enum logic [CMD_OP_W-1:0] {
        OP_LOAD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_SET  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/pf_io_delay_settle_timer.sv
// Settle timer: loadable down-counter that flags expiry after SETTLE_CYCLES.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load         load the counter (asserted in the pulse cycle)
//   o_expired_c    combinational: counter has reached zero
module pf_io_delay_settle_timer
    import pf_io_delay_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_expired_c
);

    logic [SETTLE_CNT_W-1:0] r_cnt;

    // Loaded with SETTLE_CYCLES-1 so the settle state lasts SETTLE_CYCLES cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= SETTLE_CNT_W'(SETTLE_CYCLES - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - SETTLE_CNT_W'(1);
        end
    end

    assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/pf_io_delay_ctrl.sv
// Sequencer for the dynamic delay line of one PF_IO instance.
// Accepts LOAD/INC/DEC/SET tap commands over valid/ready, issues spaced
// single-cycle LOAD/MOVE pulses, tracks a shadow tap count and flags range errors.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready       command handshake (ready only in IDLE)
//   i_cmd_op, i_cmd_arg           opcode and step count / target tap
//   o_delay_line_load/move        single-cycle pulses to the IOD
//   o_delay_line_direction        1=increment, 0=decrement
//   i_delay_line_out_of_range     range flag from the IOD
//   o_tap_value                   shadow tap count
//   o_busy, o_done, o_err_range   status
module pf_io_delay_ctrl
    import pf_io_delay_pkg::*;
#(
    parameter int unsigned TAP_W         = TAP_W_DEF,
    parameter int unsigned MAX_TAP       = MAX_TAP_DEF,
    parameter int unsigned DEFAULT_TAP   = DEFAULT_TAP_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [CMD_OP_W-1:0] i_cmd_op,
    input  logic [TAP_W-1:0]    i_cmd_arg,
    output logic                o_delay_line_load,
    output logic                o_delay_line_move,
    output logic                o_delay_line_direction,
    input  logic                i_delay_line_out_of_range,
    output logic [TAP_W-1:0]    o_tap_value,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err_range
);

    localparam logic [TAP_W:0]   MAX_TAP_EXT = (TAP_W+1)'(MAX_TAP);
    localparam logic [TAP_W-1:0] MAX_TAP_T   = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] DEF_TAP_T   = TAP_W'(DEFAULT_TAP);

    state_e           r_state, w_state_nxt;
    cmd_op_e          r_op, w_op_nxt, w_cmd_op;
    logic [TAP_W-1:0] r_arg, w_arg_nxt;
    logic [TAP_W-1:0] r_rem, w_rem_nxt;
    logic [TAP_W-1:0] r_tap, w_tap_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_err, w_err_nxt;
    logic             r_blocked, w_blocked_nxt;
    logic             r_load, w_load_nxt;
    logic             r_move, w_move_nxt;
    logic             r_done, r_ready, r_busy;
    logic             w_go_pulse;
    logic             w_timer_load;
    logic             w_expired;
    logic             w_arg_over;
    logic             w_at_limit;

    assign w_cmd_op   = cmd_op_e'(i_cmd_op);
    assign w_arg_over = ({1'b0, r_arg} > MAX_TAP_EXT);
    assign w_at_limit = r_dir ? (r_tap == MAX_TAP_T) : (r_tap == '0);

    pf_io_delay_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_timer_load),
        .o_expired_c (w_expired)
    );

    // State and registered outputs; pulses and tap updates are computed one
    // cycle ahead so they line up with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_LOAD;
            r_arg     <= '0;
            r_rem     <= '0;
            r_tap     <= DEF_TAP_T;
            r_dir     <= 1'b0;
            r_err     <= 1'b0;
            r_blocked <= 1'b0;
            r_load    <= 1'b0;
            r_move    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_arg     <= w_arg_nxt;
            r_rem     <= w_rem_nxt;
            r_tap     <= w_tap_nxt;
            r_dir     <= w_dir_nxt;
            r_err     <= w_err_nxt;
            r_blocked <= w_blocked_nxt;
            r_load    <= w_load_nxt;
            r_move    <= w_move_nxt;
            r_done    <= (w_state_nxt == ST_FIN);
            r_ready   <= (w_state_nxt == ST_IDLE);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_arg_nxt     = r_arg;
        w_rem_nxt     = r_rem;
        w_tap_nxt     = r_tap;
        w_dir_nxt     = r_dir;
        w_err_nxt     = r_err;
        w_blocked_nxt = r_blocked;
        w_load_nxt    = 1'b0;
        w_move_nxt    = 1'b0;
        w_go_pulse    = 1'b0;
        w_timer_load  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_state_nxt = ST_PREP;
                    w_op_nxt    = w_cmd_op;
                    w_arg_nxt   = i_cmd_arg;
                    w_err_nxt   = 1'b0;
                    // Direction is resolved here so it is already on the pin in PREP.
                    case (w_cmd_op)
                        OP_INC: begin
                            w_dir_nxt = 1'b1;
                            w_rem_nxt = i_cmd_arg;
                        end
                        OP_DEC: begin
                            w_dir_nxt = 1'b0;
                            w_rem_nxt = i_cmd_arg;
                        end
                        OP_SET: begin
                            if (i_cmd_arg > r_tap) begin
                                w_dir_nxt = 1'b1;
                                w_rem_nxt = i_cmd_arg - r_tap;
                            end else begin
                                w_dir_nxt = 1'b0;
                                w_rem_nxt = r_tap - i_cmd_arg;
                            end
                        end
                        default: begin
                            w_dir_nxt = 1'b0;
                            w_rem_nxt = '0;
                        end
                    endcase
                end
            end
            ST_PREP: begin
                if (r_op == OP_LOAD) begin
                    w_go_pulse = 1'b1;
                end else if ((r_op == OP_SET) && w_arg_over) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_FIN;
                end else if (r_rem == '0) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_go_pulse = 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_blocked) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_FIN;
                end else begin
                    w_timer_load = 1'b1;
                    w_state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_expired) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (i_delay_line_out_of_range) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_FIN;
                    // The IOD refused the last move: roll the shadow count back.
                    if (r_op != OP_LOAD) begin
                        w_tap_nxt = r_dir ? (r_tap - TAP_W'(1)) : (r_tap + TAP_W'(1));
                    end
                end else if (r_rem != '0) begin
                    w_go_pulse = 1'b1;
                end else begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Entry into PULSE: issue the pulse now unless the tap is already at its limit.
        if (w_go_pulse) begin
            w_state_nxt   = ST_PULSE;
            w_blocked_nxt = 1'b0;
            if (r_op == OP_LOAD) begin
                w_load_nxt = 1'b1;
                w_tap_nxt  = DEF_TAP_T;
            end else if (w_at_limit) begin
                w_blocked_nxt = 1'b1;
            end else begin
                w_move_nxt = 1'b1;
                w_tap_nxt  = r_dir ? (r_tap + TAP_W'(1)) : (r_tap - TAP_W'(1));
                w_rem_nxt  = r_rem - TAP_W'(1);
            end
        end
    end

    assign o_cmd_ready            = r_ready;
    assign o_busy                 = r_busy;
    assign o_done                 = r_done;
    assign o_delay_line_load      = r_load;
    assign o_delay_line_move      = r_move;
    assign o_delay_line_direction = r_dir;
    assign o_tap_value            = r_tap;
    assign o_err_range            = r_err;

endmodule
